// File: rtl/div_pkg.sv
// Shared widths, step-count constant and magnitude helper for the divider.
package div_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned LAST_STEP = 32;

  // Two's-complement magnitude; 0x80000000 maps to itself (read as unsigned).
  function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] x);
    return x[DIV_W-1] ? DIV_W'(~x + DIV_W'(1)) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// Combinational single restoring-division step.
// Ports:
//   r_i, q_i, d_i : current remainder, quotient/dividend shift reg, divisor magnitude
//   r_o, q_o      : remainder and quotient after one step
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] r_i,
  input  logic [DIV_W-1:0] q_i,
  input  logic [DIV_W-1:0] d_i,
  output logic [DIV_W-1:0] r_o,
  output logic [DIV_W-1:0] q_o
);

  // Trial value is carried at DIV_W+1 bits so no remainder bit is dropped.
  logic [DIV_W:0] trial;
  logic           ge;

  always_comb begin
    trial = {r_i, q_i[DIV_W-1]};
    ge    = (trial >= {1'b0, d_i});
    r_o   = ge ? DIV_W'(trial - {1'b0, d_i}) : trial[DIV_W-1:0];
    q_o   = {q_i[DIV_W-2:0], ge};
  end

endmodule

// File: rtl/div.sv
// Free-running multicycle 32-bit signed divider (quotient truncates toward zero).
// Samples operands when idle, runs 32 restoring steps, then pulses data_resultRDY
// for one cycle with the registered quotient and divide-by-zero flag.
// Ports:
//   data_operandA / data_operandB : signed dividend / divisor
//   clock, reset                  : rising-edge clock, async active-high reset
//   data_result                   : last completed quotient (registered)
//   data_exception                : last completed op divided by zero (registered)
//   data_resultRDY                : one-cycle pulse on each new result
module div
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] data_operandA,
  input  logic [DIV_W-1:0] data_operandB,
  input  logic             clock,
  output logic [DIV_W-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  input  logic             reset
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] r_q, r_d;
  logic [DIV_W-1:0] q_q, q_d;
  logic [DIV_W-1:0] d_q, d_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic [DIV_W-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [DIV_W-1:0] r_step;
  logic [DIV_W-1:0] q_step;

  div_step u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_step),
    .q_o (q_step)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  // Load / step / finish sequencing; cnt == 0 is the load slot
  always_comb begin
    cnt_d    = cnt_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    if (cnt_q == '0) begin
      q_d   = mag(data_operandA);
      d_d   = mag(data_operandB);
      r_d   = '0;
      neg_d = data_operandA[DIV_W-1] ^ data_operandB[DIV_W-1];
      dz_d  = (data_operandB == '0);
      cnt_d = CNT_W'(1);
    end else begin
      r_d   = r_step;
      q_d   = q_step;
      cnt_d = CNT_W'(cnt_q + CNT_W'(1));
      if (cnt_q == CNT_W'(LAST_STEP)) begin
        // Sign fixup on the post-step quotient; -2^31 / -1 wraps naturally.
        if (dz_q)       result_d = '0;
        else if (neg_q) result_d = DIV_W'(DIV_W'(0) - q_step);
        else            result_d = q_step;
        exc_d = dz_q;
        rdy_d = 1'b1;
        cnt_d = '0;
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_div.sv
// Directed, table-driven bench for the free-running divider.
module tb_div;

  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        clock;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        reset;

  div dut (
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .clock          (clock),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .reset          (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance edge by edge (sampling #1 after each) until RDY, bounded at 40 edges.
  // held reports whether data_result stayed at its entry value until the RDY edge.
  task automatic wait_rdy(output int n, output bit held);
    logic [31:0] start;
    start = data_result;
    held  = 1'b1;
    n     = 0;
    while (n < 40) begin
      @(posedge clock);
      #1;
      n++;
      if (data_resultRDY) break;
      if (data_result !== start) held = 1'b0;
    end
  endtask

  initial begin
    int  n;
    bit  held;

    vecs[0]  = '{32'd21,        32'd3,         32'd7,          1'b0};
    vecs[1]  = '{32'd21,        32'd3,         32'd7,          1'b0};
    vecs[2]  = '{-32'sd21,      32'd4,         32'hFFFF_FFFB,  1'b0};
    vecs[3]  = '{32'd21,        -32'sd4,       32'hFFFF_FFFB,  1'b0};
    vecs[4]  = '{-32'sd21,      -32'sd4,       32'd5,          1'b0};
    vecs[5]  = '{32'd100,       32'd0,         32'd0,          1'b1};
    vecs[6]  = '{32'd9,         32'd3,         32'd3,          1'b0};
    vecs[7]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  1'b0};
    vecs[8]  = '{32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF,  1'b0};
    vecs[9]  = '{32'h8000_0000, 32'd1,         32'h8000_0000,  1'b0};
    vecs[10] = '{32'h8000_0000, 32'h8000_0000, 32'd1,          1'b0};
    vecs[11] = '{32'd0,         32'd5,         32'd0,          1'b0};
    vecs[12] = '{-32'sd7,       32'd2,         32'hFFFF_FFFD,  1'b0};
    vecs[13] = '{32'd1000000,   32'd7,         32'd142857,     1'b0};

    reset         = 1'b1;
    data_operandA = vecs[0].a;
    data_operandB = vecs[0].b;
    #12;
    check("reset_result", data_result, 32'd0);
    check("reset_exc",    {31'd0, data_exception}, 32'd0);
    check("reset_rdy",    {31'd0, data_resultRDY}, 32'd0);

    @(negedge clock);
    reset = 1'b0;

    // Each RDY is followed immediately by the LOAD edge, so operands for the
    // next vector are applied right after the pulse is seen.
    for (int i = 0; i < NVEC; i++) begin
      wait_rdy(n, held);
      check($sformatf("v%0d_latency", i), 32'(n), 32'd33);
      check($sformatf("v%0d_result", i), data_result, vecs[i].res);
      check($sformatf("v%0d_exc", i), {31'd0, data_exception}, {31'd0, vecs[i].exc});
      check($sformatf("v%0d_held", i), {31'd0, held}, 32'd1);
      if (i + 1 < NVEC) begin
        data_operandA = vecs[i+1].a;
        data_operandB = vecs[i+1].b;
      end
    end

    // Reset in the middle of an operation: outputs clear at once, no pulse.
    data_operandA = 32'd21;
    data_operandB = 32'd3;
    held = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) held = 1'b0;
    end
    check("midrst_no_early_rdy", {31'd0, held}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_result", data_result, 32'd0);
    check("midrst_exc",    {31'd0, data_exception}, 32'd0);
    check("midrst_rdy",    {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    wait_rdy(n, held);
    check("postrst_latency", 32'(n), 32'd33);
    check("postrst_result",  data_result, 32'd7);

    // Operand change during the step phase must not affect this operation.
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
    end
    data_operandA = 32'd50;
    wait_rdy(n, held);
    check("midchg_latency", 32'(n), 32'd23);
    check("midchg_result",  data_result, 32'd7);
    wait_rdy(n, held);
    check("next_latency", 32'(n), 32'd33);
    check("next_result",  data_result, 32'd16);
    check("next_exc",     {31'd0, data_exception}, 32'd0);

    @(posedge clock);
    #1;
    check("rdy_single_cycle", {31'd0, data_resultRDY}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
